note_player: RTL and testbench

- Downstream consumer of the song reader.
- Accepts one note/duration pair per `new_note` pulse and times it in beats.
- Drives a phase accumulator whose top bits address the sine sample ROM.
- Returns a one-cycle `note_done` pulse so the reader can fetch the next note.

---
 rtl/music_defs.sv | 22 ++
 rtl/note_player_if.sv | 26 ++
 rtl/frequency_rom.sv | 35 +++
 rtl/note_player.sv | 109 ++++++++++
 tb/tb_note_player.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/music_defs.sv
// Shared widths and FSM encodings for the song playback datapath.
package music_defs;

  localparam int NOTE_WIDTH     = 6;
  localparam int DURATION_WIDTH = 6;
  localparam int STEP_WIDTH     = 20;
  localparam int PHASE_WIDTH    = 22;
  localparam int ADDR_WIDTH     = 10;
  localparam int ROM_DEPTH      = 1 << NOTE_WIDTH;

  typedef enum logic [1:0] {
    NP_IDLE    = 2'b00,
    NP_LOAD    = 2'b01,
    NP_PLAYING = 2'b10,
    NP_DONE    = 2'b11
  } np_state_e;

  function automatic logic [PHASE_WIDTH-1:0] extend_step(input logic [STEP_WIDTH-1:0] step);
    return {{(PHASE_WIDTH-STEP_WIDTH){1'b0}}, step};
  endfunction

endpackage

// File: rtl/note_player_if.sv
// Reader-to-player link: note handshake, timing strobes and sample address.
interface note_player_if;
  import music_defs::*;

  logic                      play;
  logic [NOTE_WIDTH-1:0]     note;
  logic [DURATION_WIDTH-1:0] duration;
  logic                      load_new_note;
  logic                      beat;
  logic                      generate_next_sample;
  logic                      note_done;
  logic [ADDR_WIDTH-1:0]     sample_addr;
  logic                      sample_valid;
  logic                      silent;

  modport master (
    output play, note, duration, load_new_note, beat, generate_next_sample,
    input  note_done, sample_addr, sample_valid, silent
  );

  modport slave (
    input  play, note, duration, load_new_note, beat, generate_next_sample,
    output note_done, sample_addr, sample_valid, silent
  );

endinterface

// File: rtl/frequency_rom.sv
// Note index to phase step, 1-cycle registered read. Steps are f * 2^22 / 48 kHz,
// equal temperament with A4 (440 Hz) at index 49; index 0 is the rest.
module frequency_rom
  import music_defs::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NOTE_WIDTH-1:0] addr_i,
  output logic [STEP_WIDTH-1:0] dout_o
);

  localparam logic [STEP_WIDTH-1:0] STEP_TABLE [ROM_DEPTH] = '{
    20'd0,     20'd2403,  20'd2546,  20'd2697,  20'd2858,  20'd3028,  20'd3208,  20'd3398,
    20'd3600,  20'd3815,  20'd4041,  20'd4282,  20'd4536,  20'd4806,  20'd5092,  20'd5395,
    20'd5715,  20'd6055,  20'd6415,  20'd6797,  20'd7201,  20'd7629,  20'd8083,  20'd8563,
    20'd9072,  20'd9612,  20'd10184, 20'd10789, 20'd11431, 20'd12110, 20'd12830, 20'd13593,
    20'd14402, 20'd15258, 20'd16165, 20'd17127, 20'd18145, 20'd19224, 20'd20367, 20'd21578,
    20'd22861, 20'd24221, 20'd25661, 20'd27187, 20'd28803, 20'd30516, 20'd32331, 20'd34253,
    20'd36290, 20'd38448, 20'd40734, 20'd43156, 20'd45722, 20'd48441, 20'd51322, 20'd54373,
    20'd57607, 20'd61032, 20'd64661, 20'd68506, 20'd72580, 20'd76896, 20'd81468, 20'd86312
  };

  logic [STEP_WIDTH-1:0] dout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q <= '0;
    end else begin
      dout_q <= STEP_TABLE[addr_i];
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/note_player.sv
// Times one note in beats and advances the sine phase accumulator while it plays.
//   state      | meaning
//   NP_IDLE    | waiting for load_new_note
//   NP_LOAD    | frequency ROM read in flight, step captured at end
//   NP_PLAYING | counting beats, accumulating phase when play=1
//   NP_DONE    | note_done high for this single cycle
module note_player
  import music_defs::*;
(
  input  logic clk,
  input  logic reset,
  note_player_if.slave np
);

  np_state_e                 state_q;
  logic [NOTE_WIDTH-1:0]     cur_note_q;
  logic [NOTE_WIDTH-1:0]     cur_note_d;
  logic [DURATION_WIDTH-1:0] count_q;
  logic [STEP_WIDTH-1:0]     step_q;
  logic [STEP_WIDTH-1:0]     rom_dout;
  logic [PHASE_WIDTH-1:0]    phase_q;
  logic                      note_done_q;
  logic                      sample_valid_q;
  logic                      accept_load;
  logic                      run;
  logic                      take_sample;

  assign accept_load = np.load_new_note & ((state_q == NP_IDLE) | (state_q == NP_PLAYING));
  assign run         = (state_q == NP_PLAYING) & np.play;
  assign take_sample = run & np.generate_next_sample;

  // ROM is addressed with the incoming note so its output is ready during LOAD.
  assign cur_note_d = accept_load ? np.note : cur_note_q;

  frequency_rom u_frequency_rom (
    .clk    (clk),
    .reset  (reset),
    .addr_i (cur_note_d),
    .dout_o (rom_dout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= NP_IDLE;
      cur_note_q     <= '0;
      count_q        <= '0;
      step_q         <= '0;
      phase_q        <= '0;
      note_done_q    <= 1'b0;
      sample_valid_q <= 1'b0;
    end else begin
      note_done_q    <= 1'b0;
      sample_valid_q <= take_sample;
      cur_note_q     <= cur_note_d;
      if (take_sample) begin
        phase_q <= phase_q + extend_step(step_q);
      end
      case (state_q)
        NP_IDLE: begin
          if (accept_load) begin
            count_q <= np.duration;
            state_q <= NP_LOAD;
          end
        end
        NP_LOAD: begin
          step_q <= (cur_note_q == '0) ? '0 : rom_dout;
          if (count_q == '0) begin
            note_done_q <= 1'b1;
            state_q     <= NP_DONE;
          end else begin
            state_q <= NP_PLAYING;
          end
        end
        NP_PLAYING: begin
          // A reload aborts the current note silently and swallows a coincident beat.
          if (accept_load) begin
            count_q <= np.duration;
            state_q <= NP_LOAD;
          end else if (run & np.beat) begin
            count_q <= count_q - DURATION_WIDTH'(1);
            if (count_q == DURATION_WIDTH'(1)) begin
              note_done_q <= 1'b1;
              state_q     <= NP_DONE;
            end
          end
        end
        NP_DONE: begin
          state_q <= NP_IDLE;
        end
        default: begin
          state_q <= NP_IDLE;
        end
      endcase
    end
  end

  assign np.note_done    = note_done_q;
  assign np.sample_valid = sample_valid_q;
  assign np.sample_addr  = phase_q[PHASE_WIDTH-1 -: ADDR_WIDTH];
  assign np.silent       = (state_q != NP_PLAYING) | ~np.play | (cur_note_q == '0);

  a_done_single: assert property (@(posedge clk) disable iff (reset)
    note_done_q |=> !note_done_q);
  a_count_live: assert property (@(posedge clk) disable iff (reset)
    (state_q == NP_PLAYING) |-> (count_q != '0));
  a_rest_still: assert property (@(posedge clk) disable iff (reset)
    ((state_q == NP_PLAYING) && (cur_note_q == '0)) |-> (step_q == '0));

endmodule

// File: tb/tb_note_player.sv
// Self-checking bench for note_player: vector table, corner sequences, random notes.
`timescale 1ns/1ps
module tb_note_player;
  import music_defs::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  note_player_if np_if();

  note_player dut (
    .clk   (clk),
    .reset (reset),
    .np    (np_if)
  );

  int n_tests = 0;
  int n_fail  = 0;
  longint unsigned model_phase = 0;
  int sv_seen, nd_seen, nd_step, step_no;

  typedef struct {
    int note;
    int dur;
    int spb;
    int exp_sv;
    int exp_nd;
  } vec_t;

  vec_t vecs [7];

  function automatic longint unsigned rom_ref(input int n);
    real f;
    if (n == 0) return 0;
    f = 440.0 * (2.0 ** ((n - 49) / 12.0)) * 4194304.0 / 48000.0;
    return longint'($rtoi(f + 0.5));
  endfunction

  function automatic longint unsigned addr_ref();
    return (model_phase % 64'd4194304) >> 12;
  endfunction

  task automatic add_strobes(input int note, input int count);
    model_phase = (model_phase + longint'(count) * rom_ref(note)) % 64'd4194304;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit ld, input int nt, input int du, input bit pl, input bit bt, input bit gn);
    np_if.load_new_note        = ld;
    np_if.note                 = NOTE_WIDTH'(nt);
    np_if.duration             = DURATION_WIDTH'(du);
    np_if.play                 = pl;
    np_if.beat                 = bt;
    np_if.generate_next_sample = gn;
  endtask

  task automatic win_start();
    sv_seen = 0;
    nd_seen = 0;
    nd_step = -1;
    step_no = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    step_no++;
    if (np_if.sample_valid) sv_seen++;
    if (np_if.note_done) begin
      nd_seen++;
      if (nd_step < 0) nd_step = step_no;
    end
  endtask

  task automatic run_table();
    vec_t v;
    vecs = '{'{49, 3, 2, 6, 11}, '{0, 1, 3, 3, 6}, '{10, 0, 2, 0, 2}, '{63, 4, 0, 0, 6},
             '{1, 2, 1, 2, 6}, '{63, 8, 7, 56, 66}, '{25, 1, 4, 4, 7}};
    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      win_start();
      drive(1, v.note, v.dur, 1, 0, 1); step();
      drive(0, v.note, v.dur, 1, 0, 1); step();
      check($sformatf("tbl%0d_silent_play", i), np_if.silent, (v.note == 0 || v.dur == 0) ? 1 : 0);
      for (int b = 0; b < v.dur; b++) begin
        for (int k = 0; k < v.spb; k++) begin
          drive(0, v.note, v.dur, 1, 0, 1); step();
        end
        drive(0, v.note, v.dur, 1, 1, 0); step();
      end
      drive(0, v.note, v.dur, 1, 0, 1); step(); step();
      add_strobes(v.note, v.dur * v.spb);
      check($sformatf("tbl%0d_sample_valid", i), sv_seen, v.exp_sv);
      check($sformatf("tbl%0d_done_count", i), nd_seen, 1);
      check($sformatf("tbl%0d_done_step", i), nd_step, v.exp_nd);
      check($sformatf("tbl%0d_addr", i), np_if.sample_addr, addr_ref());
      check($sformatf("tbl%0d_silent_end", i), np_if.silent, 1);
    end
  endtask

  task automatic seq_beats_apart();
    win_start();
    drive(1, 49, 3, 1, 0, 0); step();
    drive(0, 49, 3, 1, 0, 0); step();
    check("beats_silent_play", np_if.silent, 0);
    for (int b = 0; b < 3; b++) begin
      drive(0, 49, 3, 1, 0, 0);
      repeat (19) step();
      drive(0, 49, 3, 1, 1, 0); step();
    end
    check("beats_done_step", nd_step, 62);
    drive(0, 49, 3, 1, 0, 0); step(); step();
    check("beats_done_count", nd_seen, 1);
    check("beats_silent_end", np_if.silent, 1);
  endtask

  task automatic seq_pause();
    longint unsigned addr_before;
    win_start();
    drive(1, 49, 2, 1, 0, 0); step();
    drive(0, 49, 2, 1, 0, 0); step();
    drive(0, 49, 2, 1, 0, 1); step();
    add_strobes(49, 1);
    addr_before = addr_ref();
    check("pause_addr_start", np_if.sample_addr, addr_before);
    for (int k = 0; k < 5; k++) begin
      drive(0, 49, 2, 0, 1, 1); step();
    end
    check("pause_silent", np_if.silent, 1);
    check("pause_sample_valid", sv_seen, 1);
    check("pause_addr_hold", np_if.sample_addr, addr_before);
    check("pause_no_done", nd_seen, 0);
    drive(0, 49, 2, 1, 0, 0);
    #1;
    check("pause_silent_resume", np_if.silent, 0);
    step();
    drive(0, 49, 2, 1, 1, 0); step();
    check("pause_first_beat", nd_seen, 0);
    drive(0, 49, 2, 1, 1, 0); step();
    check("pause_done_step", nd_step, 11);
    drive(0, 49, 2, 1, 0, 0); step(); step();
    check("pause_done_count", nd_seen, 1);
  endtask

  task automatic seq_reload();
    win_start();
    drive(1, 20, 4, 1, 0, 0); step();
    drive(0, 20, 4, 1, 0, 0); step();
    drive(0, 20, 4, 1, 1, 0); step();
    drive(1, 30, 2, 1, 1, 0); step();
    drive(0, 30, 2, 1, 0, 0); step();
    drive(0, 30, 2, 1, 1, 0); step();
    check("reload_beat_dropped", nd_seen, 0);
    drive(0, 30, 2, 1, 1, 0); step();
    check("reload_done_step", nd_step, 7);
    drive(0, 30, 2, 1, 0, 0); step(); step();
    check("reload_done_count", nd_seen, 1);
  endtask

  task automatic seq_async_reset();
    win_start();
    drive(1, 49, 5, 1, 0, 0); step();
    drive(0, 49, 5, 1, 0, 0); step();
    drive(0, 49, 5, 1, 0, 1); step(); step(); step();
    add_strobes(49, 3);
    check("areset_addr_before", np_if.sample_addr, addr_ref());
    #2 reset = 1'b1;
    #1;
    check("areset_done", np_if.note_done, 0);
    check("areset_valid", np_if.sample_valid, 0);
    check("areset_addr", np_if.sample_addr, 0);
    check("areset_silent", np_if.silent, 1);
    #1 reset = 1'b0;
    model_phase = 0;
    win_start();
    drive(0, 49, 5, 1, 1, 1);
    repeat (8) step();
    check("areset_no_done", nd_seen, 0);
    check("areset_no_valid", sv_seen, 0);
    check("areset_addr_after", np_if.sample_addr, 0);
  endtask

  task automatic run_random();
    int nt, du, rem, strobes, exp_nd, guard;
    bit pl, bt, gn;
    for (int i = 0; i < 25; i++) begin
      nt = $urandom_range(63, 0);
      du = $urandom_range(6, 0);
      rem = du;
      strobes = 0;
      exp_nd = 2;
      guard = 0;
      win_start();
      drive(1, nt, du, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      step();
      drive(0, nt, du, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      step();
      while (rem > 0 && guard < 300) begin
        pl = ($urandom_range(3, 0) != 0);
        bt = ($urandom_range(2, 0) == 0);
        gn = 1'($urandom_range(1, 0));
        drive(0, nt, du, pl, bt, gn);
        if (pl && gn) strobes++;
        if (pl && bt) rem--;
        step();
        guard++;
        if (rem == 0) exp_nd = step_no;
      end
      check($sformatf("rnd%0d_bound", i), rem, 0);
      drive(0, nt, du, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      step(); step();
      add_strobes(nt, strobes);
      check($sformatf("rnd%0d_done_step n=%0d d=%0d", i, nt, du), nd_step, exp_nd);
      check($sformatf("rnd%0d_done_count", i), nd_seen, 1);
      check($sformatf("rnd%0d_sample_valid", i), sv_seen, strobes);
      check($sformatf("rnd%0d_addr", i), np_if.sample_addr, addr_ref());
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", np_if.note_done, 0);
    check("reset_valid", np_if.sample_valid, 0);
    check("reset_addr", np_if.sample_addr, 0);
    check("reset_silent", np_if.silent, 1);
    reset = 1'b0;
    run_table();
    seq_beats_apart();
    seq_pause();
    seq_reload();
    seq_async_reset();
    run_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
